// File: rtl/mem_interface.sv
// Memory-side access stage: steers datapath loads/stores to a synchronous
// block RAM or to a small switch/LED I/O window, returning data plus a ready pulse.
//
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   req, we         : access request (held until ready) and write select
//   adrToMem        : word address from the datapath
//   dataToMem       : write data from the datapath
//   dataFromMem     : read data, valid while ready is high and held afterwards
//   ready           : one-cycle completion pulse
//   ramAdr/ramWData : latched RAM address and write data
//   ramEn/ramWe     : one-cycle RAM strobe and write enable
//   ramRData        : RAM read data, valid the cycle after ramEn
//   switches        : asynchronous switch inputs
//   leds            : registered LED outputs
module mem_interface #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      WAIT_STATES = 0,
  parameter logic [WIDTH-1:0] IO_BASE     = 16'hFFF0,
  parameter int unsigned      SW_W        = 8,
  parameter int unsigned      LED_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [WIDTH-1:0] adrToMem,
  input  logic [WIDTH-1:0] dataToMem,
  output logic [WIDTH-1:0] dataFromMem,
  output logic             ready,
  output logic [WIDTH-1:0] ramAdr,
  output logic [WIDTH-1:0] ramWData,
  output logic             ramEn,
  output logic             ramWe,
  input  logic [WIDTH-1:0] ramRData,
  input  logic [SW_W-1:0]  switches,
  output logic [LED_W-1:0] leds
);

  typedef enum logic [1:0] {
    IDLE,
    RAM_ACC,
    RAM_WAIT,
    DONE
  } state_t;

  localparam logic [WIDTH-1:0] LED_ADR = IO_BASE + WIDTH'(1);
  localparam logic [3:0]       WS      = 4'(WAIT_STATES);

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             we_q;
  logic [WIDTH-1:0] adr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             ready_q;
  logic             ram_en_q;
  logic             ram_we_q;
  logic [LED_W-1:0] leds_q;
  logic [SW_W-1:0]  sw_meta_q;
  logic [SW_W-1:0]  sw_sync_q;

  logic             is_io;
  logic             is_sw;
  logic             is_led;
  logic [WIDTH-1:0] io_rdata;
  logic             ram_rd_done;

  always_comb begin
    is_io    = (adrToMem >= IO_BASE);
    is_sw    = (adrToMem == IO_BASE);
    is_led   = (adrToMem == LED_ADR);
    io_rdata = '0;
    if (is_sw) begin
      io_rdata = WIDTH'(sw_sync_q);
    end else if (is_led) begin
      io_rdata = WIDTH'(leds_q);
    end
  end

  // RAM read data only becomes valid during the DONE cycle, so it is
  // forwarded while ready is high and captured on the way back to IDLE.
  assign ram_rd_done = (state_q == DONE) && !we_q && (adr_q < IO_BASE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      ram_en_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      leds_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      ready_q   <= 1'b0;
      ram_en_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            adr_q   <= adrToMem;
            wdata_q <= dataToMem;
            we_q    <= we;
            if (is_io) begin
              state_q <= DONE;
              ready_q <= 1'b1;
              if (!we) begin
                rdata_q <= io_rdata;
              end else if (is_led) begin
                leds_q <= dataToMem[LED_W-1:0];
              end
            end else begin
              state_q  <= RAM_ACC;
              ram_en_q <= 1'b1;
              ram_we_q <= we;
            end
          end
        end
        RAM_ACC: begin
          cnt_q <= WS;
          if (WS == 4'd0) begin
            state_q <= DONE;
            ready_q <= 1'b1;
          end else begin
            state_q <= RAM_WAIT;
          end
        end
        RAM_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= DONE;
            ready_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (ram_rd_done) begin
            rdata_q <= ramRData;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dataFromMem = ram_rd_done ? ramRData : rdata_q;
  assign ready       = ready_q;
  assign ramAdr      = adr_q;
  assign ramWData    = wdata_q;
  assign ramEn       = ram_en_q;
  assign ramWe       = ram_we_q;
  assign leds        = leds_q;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: two instances (0 and 3 RAM wait states)
// each with a small synchronous RAM model, checked with immediate assertions.
module tb_mem_interface;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0;
  logic        req3 = 1'b0;
  logic        we = 1'b0;
  logic [15:0] adr = '0;
  logic [15:0] wdat = '0;
  logic [7:0]  sw = '0;

  logic [15:0] dfm0, ra0, rwd0;
  logic [15:0] dfm3, ra3, rwd3;
  logic        rdy0, en0, rwe0;
  logic        rdy3, en3, rwe3;
  logic [7:0]  led0, led3;
  logic [15:0] rd0 = '0;
  logic [15:0] rd3 = '0;

  logic [15:0] mem0 [256];
  logic [15:0] mem3 [256];
  int          encnt0 = 0;
  int          encnt3 = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_interface #(.WAIT_STATES(0)) u0 (
    .clk(clk), .reset(rst), .req(req0), .we(we),
    .adrToMem(adr), .dataToMem(wdat), .dataFromMem(dfm0),
    .ready(rdy0), .ramAdr(ra0), .ramWData(rwd0), .ramEn(en0),
    .ramWe(rwe0), .ramRData(rd0), .switches(sw), .leds(led0)
  );

  mem_interface #(.WAIT_STATES(3)) u3 (
    .clk(clk), .reset(rst), .req(req3), .we(we),
    .adrToMem(adr), .dataToMem(wdat), .dataFromMem(dfm3),
    .ready(rdy3), .ramAdr(ra3), .ramWData(rwd3), .ramEn(en3),
    .ramWe(rwe3), .ramRData(rd3), .switches(sw), .leds(led3)
  );

  always @(posedge clk) begin
    if (en0) begin
      encnt0 <= encnt0 + 1;
      if (rwe0) mem0[ra0[7:0]] <= rwd0;
      else      rd0 <= mem0[ra0[7:0]];
    end
    if (en3) begin
      encnt3 <= encnt3 + 1;
      if (rwe3) mem3[ra3[7:0]] <= rwd3;
      else      rd3 <= mem3[ra3[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One access on instance d (0 or 3); lat = cycles from the req-sampling
  // edge to the ready cycle, 0 if ready never arrives.
  task automatic acc(input int d, input logic w, input logic [15:0] a,
                     input logic [15:0] wd, output int lat);
    lat = 0;
    @(negedge clk);
    we = w; adr = a; wdat = wd;
    if (d == 0) req0 = 1'b1; else req3 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((d == 0) ? rdy0 : rdy3) begin
        lat = i;
        break;
      end
    end
    req0 = 1'b0;
    req3 = 1'b0;
  endtask

  initial begin
    int lat;
    int e;
    int pulses;
    int j;
    int p;
    logic [15:0] exp6 [3];
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'h0;
      mem3[i] = 16'h0;
    end
    mem3[8'h20] = 16'h1234;
    mem3[8'h21] = 16'h5678;
    mem3[8'h22] = 16'h9ABC;
    exp6[0] = 16'h1234;
    exp6[1] = 16'h5678;
    exp6[2] = 16'h9ABC;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdy0", rdy0, 1'b0);
    chk("rst_en0", en0, 1'b0);
    chk("rst_dfm0", dfm0, 16'h0);
    chk("rst_led0", led0, 8'h0);
    chk("rst_ra0", ra0, 16'h0);

    // reset during RAM_WAIT
    @(negedge clk);
    we = 1'b0; adr = 16'h0020; req3 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; req3 = 1'b0;
    @(negedge clk);
    chk("t1_rdy_a", rdy3, 1'b0);
    @(negedge clk);
    chk("t1_rdy_b", rdy3, 1'b0);
    rst = 1'b0;
    chk("t1_dfm", dfm3, 16'h0);
    chk("t1_en", en3, 1'b0);
    chk("t1_ramwe", rwe3, 1'b0);
    chk("t1_ra", ra3, 16'h0);
    chk("t1_rwd", rwd3, 16'h0);
    chk("t1_led", led3, 8'h0);
    @(negedge clk);
    chk("t1_rdy_c", rdy3, 1'b0);
    acc(3, 1'b0, 16'hFFF0, 16'h0, lat);
    chk("t1_idle_lat", lat, 1);

    // zero wait states: write then read
    e = encnt0;
    acc(0, 1'b1, 16'h0010, 16'hBEEF, lat);
    chk("t2_wr_lat", lat, 2);
    chk("t2_wr_en", encnt0 - e, 1);
    chk("t2_mem", mem0[8'h10], 16'hBEEF);
    e = encnt0;
    acc(0, 1'b0, 16'h0010, 16'h0, lat);
    chk("t2_rd_lat", lat, 2);
    chk("t2_rd_en", encnt0 - e, 1);
    chk("t2_rd_dat", dfm0, 16'hBEEF);
    @(negedge clk);
    chk("t2_rd_hold", dfm0, 16'hBEEF);

    // switches through synchroniser
    @(negedge clk);
    sw = 8'hA5;
    repeat (3) @(negedge clk);
    e = encnt0;
    acc(0, 1'b0, 16'hFFF0, 16'h0, lat);
    chk("t4_lat", lat, 1);
    chk("t4_dat", dfm0, 16'h00A5);
    chk("t4_en", encnt0 - e, 0);

    // LED write/readback and ignored I/O writes
    acc(0, 1'b1, 16'hFFF1, 16'h1F3C, lat);
    chk("t5_wr_lat", lat, 1);
    chk("t5_led", led0, 8'h3C);
    acc(0, 1'b0, 16'hFFF1, 16'h0, lat);
    chk("t5_rb", dfm0, 16'h003C);
    acc(0, 1'b1, 16'hFFF5, 16'h00FF, lat);
    chk("t5_led_keep", led0, 8'h3C);
    acc(0, 1'b1, 16'hFFF0, 16'h0077, lat);
    chk("t5_sw_wr", led0, 8'h3C);
    e = encnt0;
    acc(0, 1'b0, 16'hFFFF, 16'h0, lat);
    chk("t5_ffff_lat", lat, 1);
    chk("t5_ffff_dat", dfm0, 16'h0);
    chk("t5_ffff_en", encnt0 - e, 0);

    // three wait states
    acc(3, 1'b0, 16'h0020, 16'h0, lat);
    chk("t3_lat", lat, 5);
    chk("t3_dat", dfm3, 16'h1234);
    repeat (2) @(negedge clk);
    chk("t3_hold", dfm3, 16'h1234);

    // req held across three back-to-back reads
    e = encnt3;
    pulses = 0;
    @(negedge clk);
    we = 1'b0; adr = 16'h0020; req3 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rdy3) pulses++;
      j = (i - 1) / 6;
      p = (i - 1) % 6 + 1;
      if (j <= 2) begin
        if (p == 2) adr = 16'h0033;
        if (p == 3) chk("t6_ramadr", ra3, 16'h0020 + 16'(j));
        if (p == 5) begin
          chk("t6_rdy", rdy3, 1'b1);
          chk("t6_dat", dfm3, exp6[j]);
          adr = 16'h0021 + 16'(j);
          if (j == 2) req3 = 1'b0;
        end
        if (p == 6) chk("t6_idle", rdy3, 1'b0);
      end
    end
    chk("t6_pulses", pulses, 3);
    chk("t6_en", encnt3 - e, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
